// File: rtl/dual_helix_pkg.sv
// Shared APB request/response types and bus widths for the dual-helix slaves.
package dual_helix_pkg;

  localparam int DHS_ADDRW = 32;
  localparam int DHS_DATAW = 32;

  typedef struct packed {
    logic                   psel;
    logic                   penable;
    logic [DHS_ADDRW-1:0]   paddr;
    logic                   pwrite;
    logic [DHS_DATAW-1:0]   pwdata;
    logic [DHS_DATAW/8-1:0] pstrb;
  } dhs_apb_req_t;

  typedef struct packed {
    logic                 pready;
    logic [DHS_DATAW-1:0] prdata;
    logic                 pslverr;
  } dhs_apb_resp_t;

endpackage

// File: rtl/apb_mem_slv_decode.sv
// Address decode for apb_mem_slv: maps a byte address onto a word index and
// flags misaligned or out-of-window addresses.
module apb_mem_slv_decode
  import dual_helix_pkg::*;
#(
  parameter logic [DHS_ADDRW-1:0] BASE      = 'h0,
  parameter int unsigned          NUM_WORDS = 16
) (
  input  logic [DHS_ADDRW-1:0]         paddr,
  output logic [$clog2(NUM_WORDS)-1:0] index,
  output logic                         err
);

  localparam int unsigned          IDXW = $clog2(NUM_WORDS);
  localparam logic [DHS_ADDRW-1:0] SPAN = DHS_ADDRW'(4 * NUM_WORDS);

  logic [DHS_ADDRW-1:0] offset;

  // The full-width offset is range-checked, so an address past the window
  // is rejected instead of wrapping onto a low word.
  assign offset = paddr - BASE;
  assign index  = offset[IDXW+1:2];
  assign err    = (paddr < BASE) || (offset >= SPAN) || (paddr[1:0] != 2'b00);

endmodule

// File: rtl/apb_mem_slv.sv
// APB word-memory slave with byte strobes and error response.
// Define DHS_APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states; otherwise zero-wait.
module apb_mem_slv
  import dual_helix_pkg::*;
#(
  parameter type                  req_t       = dual_helix_pkg::dhs_apb_req_t,
  parameter type                  resp_t      = dual_helix_pkg::dhs_apb_resp_t,
  parameter logic [DHS_ADDRW-1:0] BASE        = 'h0,
  parameter int unsigned          NUM_WORDS   = 16,
  parameter int unsigned          WAIT_CYCLES = 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  req_t  req_i,
  output resp_t resp_o
);

  localparam int unsigned IDXW   = $clog2(NUM_WORDS);
  localparam logic [0:0]  IDLE   = 1'b0;
  localparam logic [0:0]  ACCESS = 1'b1;

  logic [0:0]           state;
  logic [DHS_DATAW-1:0] mem [NUM_WORDS];
  logic [IDXW-1:0]      index;
  logic                 err;
  logic                 setup;
  logic                 ready;

  apb_mem_slv_decode #(
    .BASE      (BASE),
    .NUM_WORDS (NUM_WORDS)
  ) u_decode (
    .paddr (req_i.paddr),
    .index (index),
    .err   (err)
  );

  assign setup = req_i.psel && !req_i.penable;

`ifdef DHS_APB_SLV_WAIT_EN
  logic [3:0] cnt;

  assign ready = (state == ACCESS) && (cnt == 4'd0) && req_i.psel && req_i.penable;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 4'd0;
    end else if (state == IDLE && setup) begin
      cnt <= 4'(WAIT_CYCLES);
    end else if (state == ACCESS && req_i.psel && req_i.penable && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end
`else
  assign ready = (state == ACCESS) && req_i.psel && req_i.penable;
`endif

  // Penable without a preceding setup is ignored; dropping psel mid-access aborts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (setup) state <= ACCESS;
        ACCESS:  if (!req_i.psel || ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        mem[w] <= '0;
      end
    end else if (ready && req_i.pwrite && !err) begin
      for (int b = 0; b < DHS_DATAW/8; b++) begin
        if (req_i.pstrb[b]) begin
          mem[index][8*b +: 8] <= req_i.pwdata[8*b +: 8];
        end
      end
    end
  end

  // Response is forced quiet during reset even if the FSM has not cleared yet.
  always_comb begin
    resp_o = '0;
    if (ready && !rst_i) begin
      resp_o.pready  = 1'b1;
      resp_o.pslverr = err;
      if (!req_i.pwrite && !err) begin
        resp_o.prdata = mem[index];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slv.sv
// Self-checking bench for apb_mem_slv; follows DHS_APB_SLV_WAIT_EN for expected latency.
module tb_apb_mem_slv;
  import dual_helix_pkg::*;

  localparam logic [31:0] BASE        = 32'h1000;
  localparam int          NUM_WORDS   = 16;
  localparam int          WAIT_CYCLES = 2;
`ifdef DHS_APB_SLV_WAIT_EN
  localparam int          EXP_LAT     = WAIT_CYCLES + 1;
`else
  localparam int          EXP_LAT     = 1;
`endif
  localparam int          MAX_ACC     = 40;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  dhs_apb_req_t  req;
  dhs_apb_resp_t resp;

  exp_t        exp_q[$];
  logic [31:0] model_mem [NUM_WORDS];
  vec_t        tbl [15];
  int          n_cmp = 0;
  int          n_bad = 0;

  apb_mem_slv #(
    .BASE        (BASE),
    .NUM_WORDS   (NUM_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .resp_o (resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 'h%08h, expected 'h%08h", name, act, exp);
    end
  endtask

  task automatic checkQuiet(input string name);
    checkOutput({name, "_pready"}, 32'(resp.pready), 32'h0);
    checkOutput({name, "_prdata"}, resp.prdata, 32'h0);
    checkOutput({name, "_pslverr"}, 32'(resp.pslverr), 32'h0);
  endtask

  function automatic logic model_err(input logic [31:0] addr);
    return (addr < BASE) || (addr >= BASE + 32'(4 * NUM_WORDS)) || (addr[1:0] != 2'b00);
  endfunction

  function automatic int model_idx(input logic [31:0] addr);
    return int'((addr - BASE) >> 2);
  endfunction

  function automatic vec_t make_vec(input logic wr, input logic [31:0] addr,
                                    input logic [31:0] data, input logic [3:0] strb);
    vec_t v;
    v.wr        = wr;
    v.addr      = addr;
    v.wdata     = data;
    v.strb      = strb;
    v.exp_err   = model_err(addr);
    v.exp_rdata = (!wr && !v.exp_err) ? model_mem[model_idx(addr)] : 32'h0;
    return v;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int i;
    i = model_idx(addr);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) model_mem[i][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  // One complete transfer: setup, access until pready, then scoreboard compare.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   acc;
    exp_q.push_back('{v.exp_rdata, v.exp_err});
    @(negedge clk);
    req.psel    = 1'b1;
    req.penable = 1'b0;
    req.paddr   = v.addr;
    req.pwrite  = v.wr;
    req.pwdata  = v.wdata;
    req.pstrb   = v.strb;
    #1 checkOutput("setup_pready", 32'(resp.pready), 32'h0);
    @(negedge clk);
    req.penable = 1'b1;
    acc = 1;
    #1;
    while (!resp.pready && acc < MAX_ACC) begin
      checkOutput("wait_prdata", resp.prdata, 32'h0);
      checkOutput("wait_pslverr", 32'(resp.pslverr), 32'h0);
      @(negedge clk);
      #1;
      acc++;
    end
    e = exp_q.pop_front();
    if (!resp.pready) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL timeout: pready low after %0d access cycles, addr 'h%08h", acc, v.addr);
    end else begin
      checkOutput("latency", 32'(acc), 32'(EXP_LAT));
      checkOutput("prdata", resp.prdata, e.rdata);
      checkOutput("pslverr", 32'(resp.pslverr), 32'(e.err));
      if (v.wr && !model_err(v.addr)) model_write(v.addr, v.wdata, v.strb);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    req = '0;
    for (int i = 0; i < NUM_WORDS; i++) model_mem[i] = 32'h0;

    tbl[0]  = '{1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h1004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h1008, 32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h1008, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h1008, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b0, 32'h1040, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h1002, 32'h12345678, 4'hF, 32'h0,        1'b1};
    tbl[7]  = '{1'b0, 32'h0FFC, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[8]  = '{1'b0, 32'h1004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[9]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 32'h103C, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'h103C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    tbl[12] = '{1'b1, 32'h103C, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    tbl[13] = '{1'b0, 32'h103C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    tbl[14] = '{1'b0, 32'h1008, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};

    // Reset with an active-looking request on the bus
    rst = 1'b1;
    req.psel    = 1'b1;
    req.penable = 1'b1;
    repeat (2) @(negedge clk);
    #1 checkQuiet("reset");
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    #1 checkQuiet("idle_after_reset");

    $display("[TB] table-driven vectors");
    for (int k = 0; k < 15; k++) applyStimulus(tbl[k]);
    go_idle();

    $display("[TB] abort and protocol violation");
    @(negedge clk);
    req.psel    = 1'b1;
    req.penable = 1'b0;
    req.paddr   = 32'h1000;
    req.pwrite  = 1'b1;
    req.pwdata  = 32'h55;
    req.pstrb   = 4'hF;
    @(negedge clk);
`ifdef DHS_APB_SLV_WAIT_EN
    req.penable = 1'b1;
    #1 checkOutput("abort_pready", 32'(resp.pready), 32'h0);
    @(negedge clk);
`endif
    req.psel    = 1'b0;
    req.penable = 1'b0;
    @(negedge clk);
    req.psel    = 1'b1;
    req.penable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 checkQuiet("idle_penable");
      @(negedge clk);
    end
    req = '0;
    applyStimulus(make_vec(1'b0, 32'h1000, 32'h0, 4'h0));
    go_idle();

    $display("[TB] fill then reset");
    for (int i = 0; i < NUM_WORDS; i++) begin
      applyStimulus(make_vec(1'b1, BASE + 32'(4 * i), 32'(i + 1), 4'hF));
    end
    applyStimulus(make_vec(1'b0, 32'h100C, 32'h0, 4'h0));
    @(negedge clk);
    req.psel    = 1'b1;
    req.penable = 1'b0;
    req.paddr   = 32'h100C;
    req.pwrite  = 1'b0;
    req.pstrb   = 4'h0;
    @(negedge clk);
    req.penable = 1'b1;
    for (int k = 1; k < EXP_LAT; k++) @(negedge clk);
    rst = 1'b1;
    #1 checkQuiet("reset_in_access");
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < NUM_WORDS; i++) model_mem[i] = 32'h0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      applyStimulus(make_vec(1'b0, BASE + 32'(4 * i), 32'h0, 4'h0));
    end
    go_idle();

    $display("[TB] back-to-back write/read pairs");
    for (int k = 0; k < 32; k++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      a = BASE + 32'(4 * $urandom_range(0, NUM_WORDS - 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      applyStimulus(make_vec(1'b1, a, d, s));
      applyStimulus(make_vec(1'b0, a, 32'h0, 4'h0));
    end
    go_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
